sram_req_ctrl: RTL and testbench



---
 rtl/sram_req_ctrl.sv | 146 ++++++++++++++
 tb/tb_sram_req_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: request/ready sequencer for the 256K x 16 asynchronous SRAM.
// Every pin is driven from a register; DQ is driven only during the three write states.
module sram_req_ctrl #(
    parameter int ADDR_W    = 18,
    parameter int DATA_W    = 16,
    parameter int RD_CYCLES = 2,
    parameter int WR_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        be,
    output logic              ready,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              wdone,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N
);
    localparam int MAXC = RD_CYCLES > WR_CYCLES ? RD_CYCLES : WR_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int HW   = DATA_W / 2;

    typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD} state_t;

    state_t            state, state_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic              ready_d, rvalid_d, wdone_d;
    logic              ce_n_d, oe_n_d, we_n_d, ub_n_d, lb_n_d;
    logic              dq_oe, dq_oe_d;
    logic [DATA_W-1:0] rdata_d, dq_out, dq_out_d;
    logic [ADDR_W-1:0] addr_d;

    assign SRAM_DQ = dq_oe ? dq_out : {DATA_W{1'bz}};

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        ready_d  = ready;
        rvalid_d = 1'b0;
        wdone_d  = 1'b0;
        rdata_d  = rdata;
        addr_d   = SRAM_ADDR;
        ce_n_d   = SRAM_CE_N;
        oe_n_d   = SRAM_OE_N;
        we_n_d   = SRAM_WE_N;
        ub_n_d   = SRAM_UB_N;
        lb_n_d   = SRAM_LB_N;
        dq_oe_d  = dq_oe;
        dq_out_d = dq_out;
        case (state)
            IDLE: if (req) begin
                ready_d  = 1'b0;
                addr_d   = addr;
                ce_n_d   = 1'b0;
                ub_n_d   = ~be[1];
                lb_n_d   = ~be[0];
                dq_out_d = wdata;
                if (we) begin
                    state_d = WR_SETUP;
                    dq_oe_d = 1'b1;
                end else begin
                    state_d = RD;
                    oe_n_d  = 1'b0;
                    cnt_d   = CW'(RD_CYCLES - 1);
                end
            end
            RD: if (cnt == '0) begin
                // Disabled lanes are not driven by the SRAM, so they read back as zero.
                rdata_d  = SRAM_DQ & {{HW{~SRAM_UB_N}}, {HW{~SRAM_LB_N}}};
                rvalid_d = 1'b1;
                ready_d  = 1'b1;
                ce_n_d   = 1'b1;
                oe_n_d   = 1'b1;
                ub_n_d   = 1'b1;
                lb_n_d   = 1'b1;
                state_d  = IDLE;
            end else begin
                cnt_d = cnt - 1'b1;
            end
            WR_SETUP: begin
                we_n_d  = 1'b0;
                cnt_d   = CW'(WR_CYCLES - 1);
                state_d = WR_PULSE;
            end
            WR_PULSE: if (cnt == '0) begin
                we_n_d  = 1'b1;
                state_d = WR_HOLD;
            end else begin
                cnt_d = cnt - 1'b1;
            end
            WR_HOLD: begin
                wdone_d = 1'b1;
                ready_d = 1'b1;
                ce_n_d  = 1'b1;
                ub_n_d  = 1'b1;
                lb_n_d  = 1'b1;
                dq_oe_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            ready     <= 1'b1;
            rvalid    <= 1'b0;
            wdone     <= 1'b0;
            rdata     <= '0;
            SRAM_ADDR <= '0;
            SRAM_CE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            SRAM_UB_N <= 1'b1;
            SRAM_LB_N <= 1'b1;
            dq_oe     <= 1'b0;
            dq_out    <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            ready     <= ready_d;
            rvalid    <= rvalid_d;
            wdone     <= wdone_d;
            rdata     <= rdata_d;
            SRAM_ADDR <= addr_d;
            SRAM_CE_N <= ce_n_d;
            SRAM_OE_N <= oe_n_d;
            SRAM_WE_N <= we_n_d;
            SRAM_UB_N <= ub_n_d;
            SRAM_LB_N <= lb_n_d;
            dq_oe     <= dq_oe_d;
            dq_out    <= dq_out_d;
        end
    end
endmodule

// File: tb/tb_sram_req_ctrl.sv
// tb_sram_req_ctrl: SRAM chip model, cycle-timing reference model and directed tests.
module tb_sram_req_ctrl;
    parameter int RD_CYCLES = 2;
    parameter int WR_CYCLES = 2;

    logic        clock = 1'b0;
    logic        reset, req, we;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic        ready, rvalid, wdone;
    logic [15:0] rdata;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        ce_n, oe_n, we_n, ub_n, lb_n;
    int          checks = 0;
    int          passes = 0;

    always #5 clock = ~clock;

    sram_req_ctrl #(.ADDR_W(18), .DATA_W(16), .RD_CYCLES(RD_CYCLES), .WR_CYCLES(WR_CYCLES)) dut (
        .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .ready(ready), .rvalid(rvalid), .rdata(rdata), .wdone(wdone),
        .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
        .SRAM_WE_N(we_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
    );

    // SRAM chip; disabled lanes return junk so the controller's lane masking is exercised.
    logic [15:0] mem [0:262143];
    logic [15:0] mrd;
    assign mrd = mem[sram_addr];
    assign sram_dq = (!ce_n && !oe_n && we_n) ? {ub_n ? 8'hEE : mrd[15:8], lb_n ? 8'hEE : mrd[7:0]} : 16'hzzzz;
    always @(posedge clock) begin
        if (!ce_n && !we_n) begin
            if (!ub_n) mem[sram_addr][15:8] <= sram_dq[15:8];
            if (!lb_n) mem[sram_addr][7:0]  <= sram_dq[7:0];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: position within the current operation counted in clock edges since accept.
    bit          m_active = 0, m_we = 0, m_rv = 0, m_wd = 0;
    int          m_t = 0;
    logic [17:0] m_addr = '0;
    logic [15:0] m_data = '0, m_exp = '0, m_old, m_mask;
    logic [1:0]  m_be = '0;
    logic [15:0] ref_mem [int];

    always @(posedge clock) begin
        m_rv = 0;
        m_wd = 0;
        if (reset) m_active = 0;
        else if (m_active) begin
            m_t++;
            m_mask = {{8{m_be[1]}}, {8{m_be[0]}}};
            m_old  = ref_mem.exists(int'(m_addr)) ? ref_mem[int'(m_addr)] : 16'h0000;
            if (!m_we && m_t == RD_CYCLES + 1) begin
                m_rv = 1;
                m_exp = m_old & m_mask;
                m_active = 0;
            end
            if (m_we && m_t == WR_CYCLES + 3) begin
                m_wd = 1;
                ref_mem[int'(m_addr)] = (m_old & ~m_mask) | (m_data & m_mask);
                m_active = 0;
            end
        end else if (req) begin
            m_active = 1;
            m_t = 1;
            m_we = we;
            m_addr = addr;
            m_data = wdata;
            m_be = be;
        end
    end

    bit cmp_en = 0;
    always @(negedge clock) begin
        if (cmp_en) begin
            chk("ready", ready, !m_active);
            chk("rvalid", rvalid, m_rv);
            chk("wdone", wdone, m_wd);
            if (m_rv) chk("rdata", rdata, m_exp);
            chk("ce_n", ce_n, !m_active);
            chk("oe_n", oe_n, !(m_active && !m_we));
            chk("we_n", we_n, !(m_active && m_we && m_t >= 2 && m_t <= WR_CYCLES + 1));
            chk("ub_n", ub_n, m_active ? !m_be[1] : 1'b1);
            chk("lb_n", lb_n, m_active ? !m_be[0] : 1'b1);
            chk("oe_we_overlap", !oe_n && !we_n, 1'b0);
            if (m_active) chk("sram_addr", sram_addr, m_addr);
            if (m_active && m_we) chk("dq_drive", sram_dq, m_data);
        end
    end

    task automatic op(input logic w, input logic [17:0] a, input logic [15:0] d, input logic [1:0] b,
                      output int lat, output logic [15:0] rd);
        int k = 0;
        while (!ready && k < 50) begin
            @(negedge clock);
            k++;
        end
        req = 1; we = w; addr = a; wdata = d; be = b;
        @(negedge clock);
        req = 0;
        lat = 0;
        while (!(w ? wdone : rvalid) && lat < 50) begin
            @(negedge clock);
            lat++;
        end
        rd = rdata;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, wd_cnt;
        logic [15:0] rd;
        reset = 1; req = 1; we = 1; addr = 18'h01234; wdata = 16'hFFFF; be = 2'b11;
        repeat (3) @(negedge clock);
        cmp_en = 1;
        chk("rst_ready", ready, 1'b1);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_wdone", wdone, 1'b0);
        chk("rst_strobes", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'b11111);
        chk("rst_rdata", rdata, 16'h0000);
        chk("rst_addr", sram_addr, 18'h0);
        reset = 0; req = 0;
        @(negedge clock);

        op(1'b1, 18'h00005, 16'hA5C3, 2'b11, lat, rd);
        chk("wr_latency", lat, 4);
        op(1'b0, 18'h00005, 16'h0000, 2'b11, lat, rd);
        chk("rd_latency", lat, 2);
        chk("rd_full", rd, 16'hA5C3);

        op(1'b1, 18'h00005, 16'h12FF, 2'b01, lat, rd);
        op(1'b0, 18'h00005, 16'h0000, 2'b11, lat, rd);
        chk("rd_after_byte_wr", rd, 16'hA5FF);
        op(1'b0, 18'h00005, 16'h0000, 2'b10, lat, rd);
        chk("rd_upper_lane", rd, 16'hA500);

        req = 1; we = 1; addr = 18'h3FFFF; wdata = 16'hBEEF; be = 2'b11;
        @(negedge clock);
        wd_cnt = 0;
        for (int k = 1; k <= WR_CYCLES + 4; k++) begin
            req = (k % 2 == 1) && (k < WR_CYCLES + 2);
            addr = 18'h00000; wdata = 16'hDEAD;
            @(negedge clock);
            if (wdone) wd_cnt++;
        end
        req = 0;
        chk("single_wdone", wd_cnt, 1);
        op(1'b0, 18'h3FFFF, 16'h0000, 2'b11, lat, rd);
        chk("rd_top_addr", rd, 16'hBEEF);

        req = 1; we = 1; addr = 18'h00100; wdata = 16'h7777; be = 2'b11;
        @(negedge clock);
        req = 0;
        @(negedge clock);
        chk("in_wr_pulse", we_n, 1'b0);
        reset = 1;
        @(negedge clock);
        chk("abort_we_n", we_n, 1'b1);
        chk("abort_ready", ready, 1'b1);
        chk("abort_wdone", wdone, 1'b0);
        chk("abort_ce_n", ce_n, 1'b1);
        reset = 0;
        repeat (3) @(negedge clock);
        op(1'b0, 18'h00005, 16'h0000, 2'b11, lat, rd);
        chk("rd_after_abort", rd, 16'hA5FF);

        op(1'b1, 18'h00005, 16'h0000, 2'b00, lat, rd);
        chk("be00_wr_latency", lat, 4);
        op(1'b0, 18'h00005, 16'h0000, 2'b11, lat, rd);
        chk("be00_unchanged", rd, 16'hA5FF);
        op(1'b0, 18'h00005, 16'h0000, 2'b00, lat, rd);
        chk("be00_read", rd, 16'h0000);

        op(1'b1, 18'h00000, 16'h0F0F, 2'b11, lat, rd);
        op(1'b1, 18'h20000, 16'h8001, 2'b11, lat, rd);
        op(1'b0, 18'h00000, 16'h0000, 2'b11, lat, rd);
        chk("rd_addr0", rd, 16'h0F0F);
        op(1'b0, 18'h20000, 16'h0000, 2'b01, lat, rd);
        chk("rd_low_lane", rd, 16'h0001);
        repeat (2) @(negedge clock);
        cmp_en = 0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
